// File: rtl/find_my_best.sv
// find_my_best
//   Walks the node's shared data memory looking for every neighbour whose
//   chID list contains target_ch. Among those it picks the one with the
//   highest Q-value (ties keep the lowest index), then writes the winning
//   neighbour ID (or 16'hFFFF if nothing matched) to A_BEST.
//
// Ports
//   clock      rising-edge system clock
//   rst        asynchronous active-high reset
//   en         block enable; start is ignored while low
//   start      begin a search (sampled only when idle)
//   target_ch  CH ID to look for, latched on start acceptance
//   data_in    memory read data, valid the cycle after address is driven
//   address    registered memory byte address
//   wr_en      registered memory write strobe
//   data_out   registered memory write data
//   best_id    winning neighbour ID, 16'hFFFF if none
//   best_q     winning Q-value, 0 if none
//   found      at least one neighbour matched
//   busy       high from start acceptance until the done pulse
//   done       one-cycle completion pulse
module find_my_best #(
   parameter int unsigned        WORD_W    = 16,
   parameter int unsigned        ADDR_W    = 11,
   parameter int unsigned        MAX_NBR   = 8,
   parameter int unsigned        MAX_CHID  = 8,
   parameter logic [ADDR_W-1:0]  A_NCOUNT  = 11'h274,
   parameter logic [ADDR_W-1:0]  A_CHIDCNT = 11'h278,
   parameter logic [ADDR_W-1:0]  A_CHIDS   = 11'h172,
   parameter logic [ADDR_W-1:0]  A_QVAL    = 11'h052,
   parameter logic [ADDR_W-1:0]  A_NID     = 11'h002,
   parameter logic [ADDR_W-1:0]  A_BEST    = 11'h276
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic [WORD_W-1:0] target_ch,
   input  logic [WORD_W-1:0] data_in,
   output logic [ADDR_W-1:0] address,
   output logic              wr_en,
   output logic [WORD_W-1:0] data_out,
   output logic [WORD_W-1:0] best_id,
   output logic [WORD_W-1:0] best_q,
   output logic              found,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NW = $clog2(MAX_NBR + 1);
   localparam int unsigned CW = $clog2(MAX_CHID + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_NCNT, S_RD_CCNT, S_RD_CHID, S_RD_Q,
      S_RD_NID, S_NEXT, S_WR_BEST, S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [NW-1:0]     i, i_nx, ncount, ncount_nx;
   logic [CW-1:0]     k, k_nx, ccount, ccount_nx;
   logic [WORD_W-1:0] target, target_nx, q, q_nx;
   logic [ADDR_W-1:0] address_nx;
   logic              wr_en_nx, found_nx, busy_nx, done_nx, go_wr;
   logic [WORD_W-1:0] data_out_nx, best_id_nx, best_q_nx;

   logic [NW-1:0]     i_inc, ncnt_clamp;
   logic [CW-1:0]     k_inc, ccnt_clamp;

   assign i_inc      = i + 1'b1;
   assign k_inc      = k + 1'b1;
   assign ncnt_clamp = (data_in > WORD_W'(MAX_NBR))  ? NW'(MAX_NBR)  : NW'(data_in);
   assign ccnt_clamp = (data_in > WORD_W'(MAX_CHID)) ? CW'(MAX_CHID) : CW'(data_in);

   function automatic logic [ADDR_W-1:0] chid_addr(input logic [NW-1:0] ii,
                                                   input logic [CW-1:0] kk);
      return A_CHIDS + (ADDR_W'(ii) << 4) + (ADDR_W'(kk) << 1);
   endfunction

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [NW-1:0]     ii);
      return base + (ADDR_W'(ii) << 1);
   endfunction

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         i        <= '0;
         k        <= '0;
         ncount   <= '0;
         ccount   <= '0;
         target   <= '0;
         q        <= '0;
         address  <= '0;
         wr_en    <= 1'b0;
         data_out <= '0;
         best_id  <= '1;
         best_q   <= '0;
         found    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         i        <= i_nx;
         k        <= k_nx;
         ncount   <= ncount_nx;
         ccount   <= ccount_nx;
         target   <= target_nx;
         q        <= q_nx;
         address  <= address_nx;
         wr_en    <= wr_en_nx;
         data_out <= data_out_nx;
         best_id  <= best_id_nx;
         best_q   <= best_q_nx;
         found    <= found_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

   // Every output is the registered image of its *_nx value, so each state
   // sets up the address/strobes that the following state will observe.
   always_comb begin
      state_nx    = state;
      i_nx        = i;
      k_nx        = k;
      ncount_nx   = ncount;
      ccount_nx   = ccount;
      target_nx   = target;
      q_nx        = q;
      address_nx  = address;
      wr_en_nx    = 1'b0;
      done_nx     = 1'b0;
      data_out_nx = data_out;
      best_id_nx  = best_id;
      best_q_nx   = best_q;
      found_nx    = found;
      busy_nx     = busy;
      go_wr       = 1'b0;

      case (state)
         S_IDLE: begin
            if (en && start) begin
               target_nx  = target_ch;
               found_nx   = 1'b0;
               best_q_nx  = '0;
               best_id_nx = '1;
               busy_nx    = 1'b1;
               address_nx = A_NCOUNT;
               state_nx   = S_RD_NCNT;
            end
         end
         S_RD_NCNT: begin
            ncount_nx = ncnt_clamp;
            i_nx      = '0;
            if (ncnt_clamp == '0) begin
               go_wr = 1'b1;
            end else begin
               address_nx = A_CHIDCNT;
               state_nx   = S_RD_CCNT;
            end
         end
         S_RD_CCNT: begin
            ccount_nx = ccnt_clamp;
            k_nx      = '0;
            if (ccnt_clamp == '0) begin
               state_nx = S_NEXT;
            end else begin
               address_nx = chid_addr(i, '0);
               state_nx   = S_RD_CHID;
            end
         end
         S_RD_CHID: begin
            if (data_in == target) begin
               address_nx = word_addr(A_QVAL, i);
               state_nx   = S_RD_Q;
            end else begin
               k_nx = k_inc;
               if (k_inc == ccount) begin
                  state_nx = S_NEXT;
               end else begin
                  address_nx = chid_addr(i, k_inc);
               end
            end
         end
         S_RD_Q: begin
            q_nx = data_in;
            // Strict compare: an equal Q later in the list never displaces the holder.
            if (!found || (data_in > best_q)) begin
               address_nx = word_addr(A_NID, i);
               state_nx   = S_RD_NID;
            end else begin
               state_nx = S_NEXT;
            end
         end
         S_RD_NID: begin
            best_id_nx = data_in;
            best_q_nx  = q;
            found_nx   = 1'b1;
            state_nx   = S_NEXT;
         end
         S_NEXT: begin
            i_nx = i_inc;
            if (i_inc == ncount) begin
               go_wr = 1'b1;
            end else begin
               address_nx = word_addr(A_CHIDCNT, i_inc);
               state_nx   = S_RD_CCNT;
            end
         end
         S_WR_BEST: begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx    = S_IDLE;
            address_nx  = '0;
            data_out_nx = '0;
            busy_nx     = 1'b0;
         end
      endcase

      if (go_wr) begin
         address_nx  = A_BEST;
         data_out_nx = found ? best_id : '1;
         wr_en_nx    = 1'b1;
         state_nx    = S_WR_BEST;
      end
   end

endmodule
